// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: scanned multi-digit 7-segment driver with blanking,
// PWM brightness and frame-aligned double-buffered digit data.
module seg7_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int SEG_W       = 8,
  parameter int PRESCALE    = 1000,
  parameter int BLANK       = 16,
  parameter int BRIGHT_W    = 4,
  parameter int DIG_ACT_LOW = 1,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DIGITS-1:0]          enable,
  input  logic [DIGITS*SEG_W-1:0]    seg_in,
  input  logic [BRIGHT_W-1:0]        brightness,
  output logic [SEG_W-1:0]           segment,
  output logic [DIGITS-1:0]          digit,
  output logic [$clog2(DIGITS)-1:0]  digit_idx,
  output logic                       frame_start
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int MW = PW + BRIGHT_W + 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [PW-1:0] BLANK_C  = PW'(BLANK);
  localparam logic [MW-1:0] SPAN     = MW'(PRESCALE - BLANK);

  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACT_LOW != 0}};
  localparam logic [SEG_W-1:0]  SEG_OFF = {SEG_W{SEG_ACT_LOW != 0}};

  logic [PW-1:0]     r_pre;
  logic [IW-1:0]     r_idx;
  logic [DIGITS-1:0] r_en_sh;
  logic [SEG_W-1:0]  r_seg_sh [DIGITS];
  logic [PW:0]       r_on;
  logic              r_armed;

  logic [SEG_W-1:0]  r_segment;
  logic [DIGITS-1:0] r_digit;
  logic [IW-1:0]     r_digit_idx;
  logic              r_frame_start;

  logic              w_pre_wrap;
  logic              w_bound;
  logic [MW-1:0]     w_prod;
  logic [PW:0]       w_on_next;
  logic [PW-1:0]     w_post;
  logic              w_lit;
  logic [DIGITS-1:0] w_onehot;
  logic [SEG_W-1:0]  w_seg_cur;
  logic [DIGITS-1:0] w_digit_nx;
  logic [SEG_W-1:0]  w_seg_nx;
  logic              w_fs_nx;

  always_comb begin
    w_pre_wrap = (r_pre == PRE_LAST);
    w_bound    = w_pre_wrap && (r_idx == IDX_LAST);
    // full-width product so the top brightness code reaches the whole span
    w_prod     = SPAN * (MW'(brightness) + MW'(1));
    w_on_next  = (PW+1)'(w_prod >> BRIGHT_W);
  end

  always_comb begin
    w_post    = r_pre - BLANK_C;
    w_onehot  = DIGITS'(1) << r_idx;
    w_seg_cur = r_seg_sh[r_idx];
    w_lit     = r_en_sh[r_idx]
             && (r_pre >= BLANK_C)
             && ({1'b0, w_post} < r_on);
    w_fs_nx   = r_armed && (r_pre == '0) && (r_idx == '0);
  end

  always_comb begin
    w_digit_nx = DIG_OFF;
    w_seg_nx   = SEG_OFF;
    unique case (1'b1)
      w_lit: begin
        w_digit_nx = w_onehot ^ DIG_OFF;
        w_seg_nx   = w_seg_cur ^ SEG_OFF;
      end
      default: begin
        w_digit_nx = DIG_OFF;
        w_seg_nx   = SEG_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
      if (w_pre_wrap)
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_sh <= '0;
      r_on    <= '0;
      r_armed <= 1'b0;
      for (int i = 0; i < DIGITS; i++)
        r_seg_sh[i] <= '0;
    end else if (w_bound) begin
      r_en_sh <= enable;
      r_on    <= w_on_next;
      r_armed <= 1'b1;
      for (int i = 0; i < DIGITS; i++)
        r_seg_sh[i] <= seg_in[i*SEG_W +: SEG_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_segment     <= SEG_OFF;
      r_digit       <= DIG_OFF;
      r_digit_idx   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_segment     <= w_seg_nx;
      r_digit       <= w_digit_nx;
      r_digit_idx   <= r_idx;
      r_frame_start <= w_fs_nx;
    end
  end

  assign segment     = r_segment;
  assign digit       = r_digit;
  assign digit_idx   = r_digit_idx;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: random and directed scan checks against a
// cycle-count based reference of the display timing.
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  enable;
  logic [31:0] seg_in;
  logic [1:0]  brightness;
  logic [7:0]  segment;
  logic [3:0]  digit;
  logic [1:0]  digit_idx;
  logic        frame_start;

  seg7_scan_mux #(
    .DIGITS(4), .SEG_W(8), .PRESCALE(8), .BLANK(2),
    .BRIGHT_W(2), .DIG_ACT_LOW(1), .SEG_ACT_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .enable(enable), .seg_in(seg_in),
    .brightness(brightness),
    .segment(segment), .digit(digit),
    .digit_idx(digit_idx),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int         k;
  logic [3:0] sen;
  logic [1:0] sbr;
  logic [7:0] sseg [4];
  logic [3:0] last_ed;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)",
               tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    k   = 0;
    sen = '0;
    sbr = '0;
    for (int i = 0; i < 4; i++) sseg[i] = '0;
  endtask

  task automatic step();
    int pre, idx, on;
    bit lit, efs;
    logic [3:0] oh, ed;
    logic [7:0] es;
    @(posedge clk);
    pre = k % 8;
    idx = (k / 8) % 4;
    on  = (6 * (int'(sbr) + 1)) >> 2;
    lit = sen[idx] && pre >= 2 && (pre - 2) < on;
    oh  = 4'b0001 << idx;
    ed  = lit ? ~oh : 4'hF;
    es  = lit ? sseg[idx] : 8'h00;
    efs = (k % 32 == 0) && (k > 0);
    if (k % 32 == 31) begin
      sen = enable;
      sbr = brightness;
      for (int i = 0; i < 4; i++) sseg[i] = seg_in[i*8 +: 8];
    end
    k++;
    last_ed = ed;
    #1;
    chk("digit", 32'(digit), 32'(ed));
    chk("segment", 32'(segment), 32'(es));
    chk("digit_idx", 32'(digit_idx), 32'(idx));
    chk("frame_start", 32'(frame_start), 32'(efs));
    chk("onehot", 32'($countones(~digit) <= 1), 32'd1);
    if (pre < 2) chk("blank", 32'(digit), 32'hF);
    if (digit == 4'hF) chk("seg_off", 32'(segment), 32'h0);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic reset_checks();
    chk("rst_digit", 32'(digit), 32'hF);
    chk("rst_segment", 32'(segment), 32'h0);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit found;
    rst_n      = 1'b0;
    enable     = '0;
    brightness = '0;
    seg_in     = '0;
    model_reset();
    last_ed = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();

    enable     = 4'hF;
    brightness = 2'd3;
    seg_in     = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    release_reset();
    run(64);

    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      if (last_ed == 4'b1011) found = 1'b1;
    end
    chk("found_lit_d2", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1 reset_checks();
    @(posedge clk);
    #1 reset_checks();
    release_reset();
    run(96);

    brightness = 2'd0;
    run(96);

    brightness = 2'd3;
    enable     = 4'b0101;
    run(96);

    enable = 4'hF;
    run(74);
    seg_in[7:0] = 8'h06;
    run(70);

    brightness = 2'd1;
    run(64);
    brightness = 2'd2;
    run(64);

    for (int i = 0; i < 1000; i++) begin
      enable     = 4'($urandom_range(0, 15));
      brightness = 2'($urandom_range(0, 3));
      seg_in     = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
